simon_sequence_controller: RTL and testbench

SIMON_SEQUENCE_CONTROLLER -- requirements
Module: simon_sequence_controller

---
 rtl/simon_sequence_controller.sv | 163 ++++++++++++++++
 tb/tb_simon_sequence_controller.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/simon_sequence_controller.sv
// Simon game sequencer: grows a random colour sequence, plays it on the LED,
// then checks player presses against it with a per-press timeout.
module simon_sequence_controller #(
  parameter int MAX_LEN    = 16,
  parameter int PLAY_TICKS = 4,
  parameter int GAP_TICKS  = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [1:0]                         random_seq,
  input  logic                               btn_valid,
  input  logic [1:0]                         btn_code,
  output logic                               led_valid,
  output logic [1:0]                         led_code,
  output logic [$clog2(MAX_LEN+1)-1:0]       level,
  output logic                               busy,
  output logic                               game_over,
  output logic                               win
);

  localparam int LW   = $clog2(MAX_LEN + 1);
  localparam int IW   = $clog2(MAX_LEN);
  localparam int CMAX = (TIMEOUT > PLAY_TICKS)
                        ? ((TIMEOUT > GAP_TICKS) ? TIMEOUT : GAP_TICKS)
                        : ((PLAY_TICKS > GAP_TICKS) ? PLAY_TICKS : GAP_TICKS);
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] ADD      = 3'd1;
  localparam logic [2:0] SHOW_ON  = 3'd2;
  localparam logic [2:0] SHOW_OFF = 3'd3;
  localparam logic [2:0] WAIT_IN  = 3'd4;
  localparam logic [2:0] LOSE     = 3'd5;
  localparam logic [2:0] WIN      = 3'd6;

  logic [2:0]    state, state_n;
  logic [LW-1:0] len, len_n;
  logic [IW-1:0] idx, idx_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    mem [MAX_LEN];
  logic          mem_we;
  logic [IW-1:0] wr_idx;
  logic          at_last;
  logic          cnt_done;
  logic [1:0]    cur_code;
  logic [1:0]    led_code_n;

  assign wr_idx   = len[IW-1:0];
  assign at_last  = (LW'(idx) == (len - LW'(1)));
  assign cnt_done = (cnt <= CW'(1));
  assign cur_code = mem[idx];

  always_comb begin
    state_n = state;
    len_n   = len;
    idx_n   = idx;
    cnt_n   = cnt;
    mem_we  = 1'b0;
    case (state)
      IDLE, LOSE, WIN: begin
        if (start) begin
          state_n = ADD;
          len_n   = '0;
          idx_n   = '0;
        end
      end
      ADD: begin
        mem_we  = 1'b1;
        len_n   = len + LW'(1);
        idx_n   = '0;
        cnt_n   = CW'(PLAY_TICKS);
        state_n = SHOW_ON;
      end
      SHOW_ON: begin
        if (cnt_done) begin
          state_n = SHOW_OFF;
          cnt_n   = CW'(GAP_TICKS);
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      SHOW_OFF: begin
        if (cnt_done) begin
          if (at_last) begin
            idx_n   = '0;
            state_n = WAIT_IN;
            cnt_n   = CW'(TIMEOUT);
          end else begin
            idx_n   = idx + IW'(1);
            state_n = SHOW_ON;
            cnt_n   = CW'(PLAY_TICKS);
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      WAIT_IN: begin
        // A press in the expiry cycle is evaluated before the timeout.
        if (btn_valid) begin
          if (btn_code == cur_code) begin
            if (!at_last) begin
              idx_n = idx + IW'(1);
              cnt_n = CW'(TIMEOUT);
            end else if (len < LW'(MAX_LEN)) begin
              state_n = ADD;
            end else begin
              state_n = WIN;
            end
          end else begin
            state_n = LOSE;
          end
        end else if (cnt_done) begin
          state_n = LOSE;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // The first step shown after ADD may be the entry written on that same edge.
  always_comb begin
    led_code_n = '0;
    if (state_n == SHOW_ON) begin
      if (mem_we && (idx_n == wr_idx)) led_code_n = random_seq;
      else                             led_code_n = mem[idx_n];
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[wr_idx] <= random_seq;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      len       <= '0;
      idx       <= '0;
      cnt       <= '0;
      led_valid <= 1'b0;
      led_code  <= '0;
      level     <= '0;
      busy      <= 1'b0;
      game_over <= 1'b0;
      win       <= 1'b0;
    end else begin
      state     <= state_n;
      len       <= len_n;
      idx       <= idx_n;
      cnt       <= cnt_n;
      led_valid <= (state_n == SHOW_ON);
      led_code  <= led_code_n;
      level     <= len_n;
      busy      <= !((state_n == IDLE) || (state_n == LOSE) || (state_n == WIN));
      game_over <= (state_n == LOSE);
      win       <= (state_n == WIN);
    end
  end

endmodule

// File: tb/tb_simon_sequence_controller.sv
// Directed bench for simon_sequence_controller: expected output vectors are
// queued as each cycle's stimulus is driven and checked after the clock edge.
module tb_simon_sequence_controller;

  localparam int MAX_LEN    = 4;
  localparam int PLAY_TICKS = 3;
  localparam int GAP_TICKS  = 2;
  localparam int TIMEOUT    = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [1:0] random_seq = '0;
  logic       btn_valid = 1'b0;
  logic [1:0] btn_code = '0;
  logic       led_valid;
  logic [1:0] led_code;
  logic [2:0] level;
  logic       busy;
  logic       game_over;
  logic       win;

  simon_sequence_controller #(
    .MAX_LEN   (MAX_LEN),
    .PLAY_TICKS(PLAY_TICKS),
    .GAP_TICKS (GAP_TICKS),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .random_seq(random_seq),
    .btn_valid (btn_valid),
    .btn_code  (btn_code),
    .led_valid (led_valid),
    .led_code  (led_code),
    .level     (level),
    .busy      (busy),
    .game_over (game_over),
    .win       (win)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         passes = 0;
  logic [8:0] exp_q[$];
  string      tag_q[$];

  logic [1:0] seq_m [MAX_LEN];
  int         len_m = 0;
  int         idx_m = 0;

  function automatic logic [8:0] ev(input bit lv, input logic [1:0] code, input int lvl,
                                    input bit bz, input bit go, input bit w);
    return {lv, code, 3'(lvl), bz, go, w};
  endfunction

  task automatic step(input string tag, input logic [8:0] exp);
    logic [8:0] e;
    logic [8:0] obs;
    string      t;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    e   = exp_q.pop_front();
    t   = tag_q.pop_front();
    obs = {led_valid, led_code, level, busy, game_over, win};
    checks++;
    assert (obs === e) passes++;
    else $error("FAIL %s: observed %b expected %b (lv,code,level,busy,over,win)", t, obs, e);
  endtask

  task automatic start_game();
    start = 1'b1;
    step("start", ev(0, 2'd0, 0, 1, 0, 0));
    start = 1'b0;
    len_m = 0;
    idx_m = 0;
  endtask

  task automatic add(input logic [1:0] code);
    seq_m[len_m] = code;
    len_m++;
    random_seq = code;
    step("add_led", ev(1, seq_m[0], len_m, 1, 0, 0));
    random_seq = ~code;
  endtask

  task automatic show(input bit noise);
    for (int i = 0; i < len_m; i++) begin
      for (int t = 0; t < PLAY_TICKS; t++) begin
        if (i == 0 && t == 0) continue;
        btn_valid = noise;
        btn_code  = seq_m[i] + 2'd1;
        start     = noise && (t % 2 == 0);
        step("show_on", ev(1, seq_m[i], len_m, 1, 0, 0));
      end
      for (int t = 0; t < GAP_TICKS; t++) begin
        btn_valid = noise;
        btn_code  = seq_m[i] + 2'd2;
        start     = noise;
        step("show_off", ev(0, 2'd0, len_m, 1, 0, 0));
      end
    end
    btn_valid = 1'b0;
    start     = 1'b0;
    step("wait_entry", ev(0, 2'd0, len_m, 1, 0, 0));
    idx_m = 0;
  endtask

  task automatic press(input logic [1:0] code);
    logic [8:0] e;
    if (code == seq_m[idx_m]) begin
      if (idx_m < len_m - 1) begin
        idx_m++;
        e = ev(0, 2'd0, len_m, 1, 0, 0);
      end else if (len_m < MAX_LEN) begin
        e = ev(0, 2'd0, len_m, 1, 0, 0);
      end else begin
        e = ev(0, 2'd0, len_m, 0, 0, 1);
      end
    end else begin
      e = ev(0, 2'd0, len_m, 0, 1, 0);
    end
    btn_valid = 1'b1;
    btn_code  = code;
    step("press", e);
    btn_valid = 1'b0;
  endtask

  task automatic idle_wait(input int n);
    for (int k = 0; k < n; k++) step("wait_idle", ev(0, 2'd0, len_m, 1, 0, 0));
  endtask

  initial begin
    // Reset, then quiet idle.
    rst = 1'b1;
    step("reset0", '0);
    step("reset1", '0);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) step("idle", '0);

    // Game 1: first round, then timeout behaviour in round 2.
    start_game();
    add(2'd2);
    show(1'b0);
    press(2'd2);
    add(2'd3);
    show(1'b1);
    idle_wait(TIMEOUT - 1);
    press(2'd2);
    idle_wait(TIMEOUT - 1);
    step("timeout_lose", ev(0, 2'd0, 2, 0, 1, 0));
    btn_valid = 1'b1;
    btn_code  = 2'd3;
    step("lose_sticky0", ev(0, 2'd0, 2, 0, 1, 0));
    step("lose_sticky1", ev(0, 2'd0, 2, 0, 1, 0));
    btn_valid = 1'b0;

    // Game 2: full win with codes 1,3,0,2.
    start_game();
    add(2'd1); show(1'b0); press(2'd1);
    add(2'd3); show(1'b1); press(2'd1); press(2'd3);
    add(2'd0); show(1'b0); press(2'd1); press(2'd3); press(2'd0);
    add(2'd2); show(1'b0); press(2'd1); press(2'd3); press(2'd0); press(2'd2);
    step("win_sticky0", ev(0, 2'd0, 4, 0, 0, 1));
    step("win_sticky1", ev(0, 2'd0, 4, 0, 0, 1));

    // Game 3: wrong press in round 2, restart, then reset during round 3.
    start_game();
    add(2'd1); show(1'b0); press(2'd1);
    add(2'd2); show(1'b0); press(2'd3);
    step("lose_hold", ev(0, 2'd0, 2, 0, 1, 0));
    start_game();
    add(2'd1); show(1'b0); press(2'd1);
    add(2'd0); show(1'b0); press(2'd1); press(2'd0);
    add(2'd3);
    step("r3_show_on", ev(1, seq_m[0], 3, 1, 0, 0));
    rst       = 1'b1;
    btn_valid = 1'b1;
    start     = 1'b1;
    step("mid_reset", '0);
    rst       = 1'b0;
    btn_valid = 1'b0;
    start     = 1'b0;
    for (int k = 0; k < 3; k++) step("post_reset_idle", '0);

    // Fresh game after the abort.
    start_game();
    add(2'd0);
    show(1'b0);
    press(2'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
